// File: rtl/idex_hazard_reg_if.sv
// Signal bundle between the decode stage, the ID/EX register and the hazard/EX consumers.
// master drives the decode side and stall/flush requests; slave is the ID/EX register.
interface idex_hazard_reg_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  mem_stall;
    logic                  flush;
    logic [8:0]            ID_ctrl;
    logic [REG_ADDR_W-1:0] ID_reg_rs;
    logic [REG_ADDR_W-1:0] ID_reg_rt;
    logic [REG_ADDR_W-1:0] ID_reg_rd;
    logic [DATA_W-1:0]     ID_read_data_1;
    logic [DATA_W-1:0]     ID_read_data_2;
    logic [DATA_W-1:0]     ID_imm;
    logic [DATA_W-1:0]     ID_pc_plus4;

    logic [8:0]            IDEX_ctrl;
    logic [REG_ADDR_W-1:0] IDEX_reg_rs;
    logic [REG_ADDR_W-1:0] IDEX_reg_rt;
    logic [REG_ADDR_W-1:0] IDEX_reg_rd;
    logic [DATA_W-1:0]     IDEX_read_data_1;
    logic [DATA_W-1:0]     IDEX_read_data_2;
    logic [DATA_W-1:0]     IDEX_imm;
    logic [DATA_W-1:0]     IDEX_pc_plus4;
    logic                  pc_write;
    logic                  IFID_write;
    logic                  load_use_stall;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output mem_stall, flush, ID_ctrl, ID_reg_rs, ID_reg_rt, ID_reg_rd,
               ID_read_data_1, ID_read_data_2, ID_imm, ID_pc_plus4,
        input  IDEX_ctrl, IDEX_reg_rs, IDEX_reg_rt, IDEX_reg_rd,
               IDEX_read_data_1, IDEX_read_data_2, IDEX_imm, IDEX_pc_plus4,
               pc_write, IFID_write, load_use_stall, stall_count
    );

    modport slave (
        input  mem_stall, flush, ID_ctrl, ID_reg_rs, ID_reg_rt, ID_reg_rd,
               ID_read_data_1, ID_read_data_2, ID_imm, ID_pc_plus4,
        output IDEX_ctrl, IDEX_reg_rs, IDEX_reg_rt, IDEX_reg_rd,
               IDEX_read_data_1, IDEX_read_data_2, IDEX_imm, IDEX_pc_plus4,
               pc_write, IFID_write, load_use_stall, stall_count
    );
endinterface

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard/flush, freeze on memory stall and a saturating stall-cycle counter.
module idex_hazard_reg #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic         clk,
    input  logic         rst,
    idex_hazard_reg_if.slave bus
);
    logic [8:0]            ctrl_q,    ctrl_d;
    logic [REG_ADDR_W-1:0] rs_q,      rs_d;
    logic [REG_ADDR_W-1:0] rt_q,      rt_d;
    logic [REG_ADDR_W-1:0] rd_q,      rd_d;
    logic [DATA_W-1:0]     rdata1_q,  rdata1_d;
    logic [DATA_W-1:0]     rdata2_q,  rdata2_d;
    logic [DATA_W-1:0]     imm_q,     imm_d;
    logic [DATA_W-1:0]     pc4_q,     pc4_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;

    logic load_use;
    logic stall_any;

    // A load in EX whose destination is read by the instruction in ID; r0 never hazards.
    assign load_use  = ctrl_q[2] && (rt_q != '0) &&
                       ((rt_q == bus.ID_reg_rs) || (rt_q == bus.ID_reg_rt));
    assign stall_any = load_use || bus.mem_stall;

    always_comb begin
        ctrl_d   = ctrl_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        rd_d     = rd_q;
        rdata1_d = rdata1_q;
        rdata2_d = rdata2_q;
        imm_d    = imm_q;
        pc4_d    = pc4_q;
        cnt_d    = cnt_q;

        if (!bus.mem_stall) begin
            rs_d     = bus.ID_reg_rs;
            rt_d     = bus.ID_reg_rt;
            rd_d     = bus.ID_reg_rd;
            rdata1_d = bus.ID_read_data_1;
            rdata2_d = bus.ID_read_data_2;
            imm_d    = bus.ID_imm;
            pc4_d    = bus.ID_pc_plus4;
            ctrl_d   = (bus.flush || load_use) ? 9'h000 : bus.ID_ctrl;
        end

        if (stall_any && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
            cnt_q    <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc4_q    <= pc4_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.IDEX_ctrl        = ctrl_q;
    assign bus.IDEX_reg_rs      = rs_q;
    assign bus.IDEX_reg_rt      = rt_q;
    assign bus.IDEX_reg_rd      = rd_q;
    assign bus.IDEX_read_data_1 = rdata1_q;
    assign bus.IDEX_read_data_2 = rdata2_q;
    assign bus.IDEX_imm         = imm_q;
    assign bus.IDEX_pc_plus4    = pc4_q;
    assign bus.pc_write         = !stall_any;
    assign bus.IFID_write       = !stall_any;
    assign bus.load_use_stall   = load_use;
    assign bus.stall_count      = cnt_q;
endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed bench for idex_hazard_reg: a default instance plus a CNT_W=4 instance
// used only to observe counter saturation.
module tb_idex_hazard_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    idex_hazard_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) b1 ();
    idex_hazard_reg_if #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4))  b2 ();

    idex_hazard_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    idex_hazard_reg #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (b2.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [8:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic [31:0] pc4);
        b1.ID_ctrl        = ctrl;
        b1.ID_reg_rs      = rs;
        b1.ID_reg_rt      = rt;
        b1.ID_reg_rd      = rd;
        b1.ID_read_data_1 = d1;
        b1.ID_read_data_2 = d2;
        b1.ID_imm         = imm;
        b1.ID_pc_plus4    = pc4;
    endtask

    initial begin
        b1.mem_stall = 1'b0;
        b1.flush     = 1'b0;
        set_id(9'h000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        b2.mem_stall = 1'b0;
        b2.flush     = 1'b0;
        b2.ID_ctrl = 9'h0; b2.ID_reg_rs = 5'd0; b2.ID_reg_rt = 5'd0; b2.ID_reg_rd = 5'd0;
        b2.ID_read_data_1 = 32'h0; b2.ID_read_data_2 = 32'h0;
        b2.ID_imm = 32'h0; b2.ID_pc_plus4 = 32'h0;

        #12;
        chk("rst_ctrl", 64'(b1.IDEX_ctrl), 64'h0);
        chk("rst_cnt",  64'(b1.stall_count), 64'h0);
        chk("rst_pcw",  64'(b1.pc_write), 64'h1);
        rst = 1'b0;
        step();

        // Load-use via rs match
        set_id(9'h007, 5'd1, 5'd5, 5'd0, 32'h11, 32'h22, 32'h33, 32'h44);
        step();
        chk("lw_ctrl", 64'(b1.IDEX_ctrl), 64'h007);
        chk("lw_rt",   64'(b1.IDEX_reg_rt), 64'd5);
        set_id(9'h041, 5'd5, 5'd6, 5'd7, 32'hAAAA, 32'hBBBB, 32'h10, 32'h104);
        #1;
        chk("lu_stall", 64'(b1.load_use_stall), 64'h1);
        chk("lu_pcw",   64'(b1.pc_write), 64'h0);
        chk("lu_ifid",  64'(b1.IFID_write), 64'h0);
        step();
        chk("lu_bubble", 64'(b1.IDEX_ctrl), 64'h0);
        chk("lu_cnt",    64'(b1.stall_count), 64'd1);
        chk("lu_d1",     64'(b1.IDEX_read_data_1), 64'hAAAA);
        chk("lu_clear",  64'(b1.pc_write), 64'h1);
        step();
        chk("lu_reissue", 64'(b1.IDEX_ctrl), 64'h041);
        chk("lu_rd",      64'(b1.IDEX_reg_rd), 64'd7);
        chk("lu_pc4",     64'(b1.IDEX_pc_plus4), 64'h104);

        // Load-use via rt match
        set_id(9'h004, 5'd2, 5'd7, 5'd0, 32'h1, 32'h2, 32'h3, 32'h4);
        step();
        set_id(9'h001, 5'd3, 5'd7, 5'd8, 32'h5, 32'h6, 32'h7, 32'h8);
        #1;
        chk("lu_rt_stall", 64'(b1.load_use_stall), 64'h1);
        step();
        chk("lu_rt_bubble", 64'(b1.IDEX_ctrl), 64'h0);
        chk("lu_rt_cnt",    64'(b1.stall_count), 64'd2);

        // Register 0 never hazards
        set_id(9'h004, 5'd4, 5'd0, 5'd0, 32'h9, 32'h9, 32'h9, 32'h9);
        step();
        set_id(9'h021, 5'd0, 5'd0, 5'd9, 32'hCAFE, 32'hBEEF, 32'hFFFF_FFF0, 32'h200);
        #1;
        chk("r0_stall", 64'(b1.load_use_stall), 64'h0);
        chk("r0_pcw",   64'(b1.pc_write), 64'h1);
        step();
        chk("r0_ctrl", 64'(b1.IDEX_ctrl), 64'h021);
        chk("r0_d2",   64'(b1.IDEX_read_data_2), 64'hBEEF);
        chk("r0_imm",  64'(b1.IDEX_imm), 64'hFFFF_FFF0);
        chk("r0_cnt",  64'(b1.stall_count), 64'd2);

        // Flush
        b1.flush = 1'b1;
        set_id(9'h043, 5'd10, 5'd11, 5'd12, 32'h1234, 32'h5678, 32'h1, 32'h300);
        step();
        b1.flush = 1'b0;
        chk("fl_ctrl", 64'(b1.IDEX_ctrl), 64'h0);
        chk("fl_d1",   64'(b1.IDEX_read_data_1), 64'h1234);
        chk("fl_cnt",  64'(b1.stall_count), 64'd2);

        // Freeze for 3 cycles, flush asserted during one of them
        set_id(9'h0C1, 5'd13, 5'd14, 5'd15, 32'hD1, 32'hD2, 32'hD3, 32'h400);
        step();
        chk("fz_load", 64'(b1.IDEX_ctrl), 64'h0C1);
        b1.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(9'h1FF, 5'(i + 20), 5'(i + 21), 5'(i + 22),
                   32'(i + 100), 32'(i + 200), 32'(i + 300), 32'(i + 500));
            b1.flush = (i == 1);
            #1;
            chk("fz_pcw", 64'(b1.pc_write), 64'h0);
            step();
            chk("fz_ctrl", 64'(b1.IDEX_ctrl), 64'h0C1);
            chk("fz_d1",   64'(b1.IDEX_read_data_1), 64'hD1);
            chk("fz_rs",   64'(b1.IDEX_reg_rs), 64'd13);
            chk("fz_pc4",  64'(b1.IDEX_pc_plus4), 64'h400);
        end
        b1.mem_stall = 1'b0;
        b1.flush     = 1'b0;
        chk("fz_cnt", 64'(b1.stall_count), 64'd5);
        set_id(9'h003, 5'd16, 5'd17, 5'd18, 32'hE1, 32'hE2, 32'hE3, 32'h500);
        step();
        chk("fz_resume", 64'(b1.IDEX_ctrl), 64'h003);
        chk("fz_res_d1", 64'(b1.IDEX_read_data_1), 64'hE1);

        // Saturation on the 4-bit counter instance
        b2.mem_stall = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 13) chk("sat_14", 64'(b2.stall_count), 64'hE);
            if (i == 14) chk("sat_15", 64'(b2.stall_count), 64'hF);
        end
        chk("sat_end", 64'(b2.stall_count), 64'hF);
        b2.mem_stall = 1'b0;

        // Asynchronous reset mid-stream
        set_id(9'h1FF, 5'd1, 5'd2, 5'd3, 32'hF1, 32'hF2, 32'hF3, 32'hF4);
        step();
        chk("pre_rst_ctrl", 64'(b1.IDEX_ctrl), 64'h1FF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ctrl", 64'(b1.IDEX_ctrl), 64'h0);
        chk("arst_d1",   64'(b1.IDEX_read_data_1), 64'h0);
        chk("arst_rt",   64'(b1.IDEX_reg_rt), 64'h0);
        chk("arst_cnt",  64'(b1.stall_count), 64'h0);
        chk("arst_sat",  64'(b2.stall_count), 64'h0);
        step();
        chk("arst_hold", 64'(b1.IDEX_ctrl), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
